// File: rtl/sigdel_dac_mc_if.sv
// Sample-write bus for sigdel_dac_mc: channel-addressed sample writes plus a global load strobe.
// Handshake: a write transfers on a rising clk edge where in_valid=1 and in_ready=1; in_ready never
// depends on in_valid; in_chan/in_DAC are only meaningful while in_valid=1; load needs no handshake.
interface sigdel_dac_mc_if #(
  parameter int BITLEN = 16,
  parameter int NCH    = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_chan;
  logic [BITLEN-1:0] in_DAC;
  logic              load;

  modport master (output in_valid, in_chan, in_DAC, load, input in_ready);
  modport slave  (input in_valid, in_chan, in_DAC, load, output in_ready);
endinterface

// File: rtl/sigdel_dac_mc.sv
// Multi-channel sigma-delta DAC: shadow/active sample registers feeding one 1st- or 2nd-order
// modulator per channel. Define SIGDEL_DITHER_EN to add a 1-LSB LFSR dither to every quantiser.
module sigdel_dac_mc #(
  parameter int BITLEN = 16,
  parameter int NCH    = 4,
  parameter int ORDER  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  sigdel_dac_mc_if.slave bus,
  output logic [NCH-1:0] out
);

  // Reset asserts asynchronously; release is retimed through two flops.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n      = r_rst_sync[1];
  assign bus.in_ready = w_rst_n;

  logic [BITLEN-1:0] r_shadow [NCH];
  logic [BITLEN-1:0] r_active [NCH];

  // Load copies the pre-edge shadow, so a same-edge write lands in the shadow only.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        r_shadow[c] <= '0;
        r_active[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.load) r_active[c] <= r_shadow[c];
        if (bus.in_valid && (int'(bus.in_chan) == c)) r_shadow[c] <= bus.in_DAC;
      end
    end
  end

  logic w_dither;

`ifdef SIGDEL_DITHER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)  r_lfsr <= 16'hACE1;
    else if (en)   r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_dither = r_lfsr[0];
`else
  assign w_dither = 1'b0;
`endif

  generate
    if (ORDER == 1) begin : g_o1
      for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [BITLEN-1:0] r_acc;
        logic              r_out;
        logic [BITLEN:0]   w_sum;

        assign w_sum = {1'b0, r_acc} + {1'b0, r_active[c]} + {{BITLEN{1'b0}}, w_dither};

        always_ff @(posedge clk or negedge w_rst_n) begin
          if (!w_rst_n) begin
            r_acc <= '0;
            r_out <= 1'b0;
          end else if (en) begin
            r_acc <= w_sum[BITLEN-1:0];
            r_out <= w_sum[BITLEN];
          end else begin
            r_out <= 1'b0;
          end
        end

        assign out[c] = r_out;
      end
    end else if (ORDER == 2) begin : g_o2
      // Integrators are BITLEN+4 wide; sums are formed two bits wider so the clamp sees true overflow.
      localparam int IW     = BITLEN + 4;
      localparam int EW     = BITLEN + 6;
      localparam int SMAX_I = (1 << (BITLEN + 2)) - 1;
      localparam int HALF_I = 1 << (BITLEN - 1);
      localparam logic signed [EW-1:0] SMAX = EW'(SMAX_I);
      localparam logic signed [EW-1:0] SMIN = -SMAX;
      localparam logic signed [EW-1:0] HALF = EW'(HALF_I);
      localparam logic signed [EW-1:0] ZERO = '0;

      function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SMAX)      return SMAX[IW-1:0];
        else if (v < SMIN) return SMIN[IW-1:0];
        else               return v[IW-1:0];
      endfunction

      for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic signed [IW-1:0] r_i1;
        logic signed [IW-1:0] r_i2;
        logic                 r_out;
        logic signed [EW-1:0] w_xs;
        logic signed [EW-1:0] w_fb;
        logic signed [EW-1:0] w_i1_raw;
        logic signed [EW-1:0] w_i2_raw;
        logic signed [EW-1:0] w_q;
        logic signed [IW-1:0] w_i1_new;
        logic signed [IW-1:0] w_i2_new;

        assign w_xs     = $signed({{(EW-BITLEN){1'b0}}, r_active[c]}) - HALF;
        assign w_fb     = r_out ? HALF : -HALF;
        assign w_i1_raw = $signed({{2{r_i1[IW-1]}}, r_i1}) + w_xs - w_fb;
        assign w_i1_new = sat(w_i1_raw);
        assign w_i2_raw = $signed({{2{r_i2[IW-1]}}, r_i2})
                        + $signed({{2{w_i1_new[IW-1]}}, w_i1_new}) - w_fb;
        assign w_i2_new = sat(w_i2_raw);
        // Dither only nudges the comparison; the stored integrator stays undithered.
        assign w_q      = $signed({{2{w_i2_new[IW-1]}}, w_i2_new})
                        + $signed({{(EW-1){1'b0}}, w_dither});

        always_ff @(posedge clk or negedge w_rst_n) begin
          if (!w_rst_n) begin
            r_i1  <= '0;
            r_i2  <= '0;
            r_out <= 1'b0;
          end else if (en) begin
            r_i1  <= w_i1_new;
            r_i2  <= w_i2_new;
            r_out <= (w_q >= ZERO);
          end else begin
            r_out <= 1'b0;
          end
        end

        assign out[c] = r_out;
      end
    end else begin : g_bad_order
      $error("sigdel_dac_mc: ORDER must be 1 or 2");
    end
  endgenerate

endmodule
